fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if_id_reg.sv | 31 +++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, defaults,
// FSM encoding, IF/ID record layout and a saturating counter helper.
package fetch_pkg;

  localparam int          ADDR_W        = 16;
  localparam int          PC_STEP_DFLT  = 2;
  localparam logic [15:0] NOP_WORD_DFLT = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] instr;
    logic [ADDR_W-1:0] pc_next;
  } if_id_t;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, otherwise holds.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_next_in,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc_next
);

  if_id_t q;

  // bubble -> NOP with zero pc_next, load -> real instruction, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= '{valid: 1'b0, instr: NOP_WORD, pc_next: 16'h0000};
    else if (bubble) q <= '{valid: 1'b0, instr: NOP_WORD, pc_next: 16'h0000};
    else if (load)   q <= '{valid: 1'b1, instr: instr_in, pc_next: pc_next_in};
  end

  assign valid   = q.valid;
  assign instr   = q.instr;
  assign pc_next = q.pc_next;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HOLD control, next-PC selection,
// IF/ID register and saturating fetch/squash counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          PC_STEP  = PC_STEP_DFLT,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] new_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_next,
  output logic        misalign,
  output logic [15:0] fetch_count,
  output logic [15:0] squash_count
);

  localparam logic [15:0] STEP = 16'(PC_STEP);

  fetch_state_t state;
  logic         redirect, advance, stall_hold;
  logic [15:0]  seq_pc, tgt_pc;

  assign seq_pc    = pc + STEP;                     // wraps mod 2^16
  assign tgt_pc    = {branch_target[15:1], 1'b0};   // force halfword alignment
  assign imem_addr = pc;

  // per-cycle action; redirect has priority over stall, BOOT ignores both
  always_comb begin
    redirect   = 1'b0;
    advance    = 1'b0;
    stall_hold = 1'b0;
    if (state != BOOT) begin
      if (branch_taken) redirect   = 1'b1;
      else if (stall)   stall_hold = 1'b1;
      else              advance    = 1'b1;
    end
  end

  // next-PC mux; PC register reloads pc unchanged in reset, BOOT and stall
  always_comb begin
    new_pc = pc;
    if (!reset) begin
      if (redirect)     new_pc = tgt_pc;
      else if (advance) new_pc = seq_pc;
    end
  end

  // control FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        default: state <= stall_hold ? HOLD : RUN;
      endcase
    end
  end

  // sticky misalign flag and saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign     <= 1'b0;
      fetch_count  <= 16'h0000;
      squash_count <= 16'h0000;
    end else begin
      if (redirect && branch_target[0]) misalign <= 1'b1;
      if (advance)  fetch_count  <= sat_inc(fetch_count);
      if (redirect) squash_count <= sat_inc(squash_count);
    end
  end

  // BOOT writes an invalid entry so the first real fetch starts clean
  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (advance),
    .bubble     (redirect || (state == BOOT)),
    .instr_in   (imem_data),
    .pc_next_in (seq_pc),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc_next    (if_id_pc_next)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process acts as PC register
// and instruction memory, pushes the expected outcome of every cycle, and a
// separate monitor pops and compares.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [15:0] new_pc, imem_addr, imem_data;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        if_id_valid, misalign;
  logic [15:0] if_id_instr, if_id_pc_next, fetch_count, squash_count;

  logic [15:0] mem [0:255];
  int tests = 0, fails = 0, pushed = 0, popped = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] new_pc;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pcn;
    logic [15:0] fc;
    logic [15:0] sc;
    logic        mis;
  } exp_t;
  exp_t q[$];

  // reference model state (architectural view, not RTL encoding)
  logic        booting;
  logic [15:0] m_pc, m_instr, m_pcn, m_fc, m_sc;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[8:1]];

  fetch_unit #(.PC_STEP(2), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .reset(reset), .pc(pc), .new_pc(new_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc_next(if_id_pc_next),
    .misalign(misalign), .fetch_count(fetch_count), .squash_count(squash_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    booting = 1'b1;
    m_valid = 1'b0; m_instr = 16'h0000; m_pcn = 16'h0000;
    m_fc = 16'h0000; m_sc = 16'h0000; m_mis = 1'b0;
  endtask

  // one fetch cycle: drive inputs at negedge, predict the cycle's outcome
  task automatic step(input logic s, input logic b, input logic [15:0] t);
    exp_t e;
    logic [15:0] nx;
    @(negedge clk);
    pc = m_pc; stall = s; branch_taken = b; branch_target = t;
    if (booting) begin
      nx = m_pc; m_valid = 1'b0; m_instr = 16'h0000; m_pcn = 16'h0000;
      booting = 1'b0;
    end else if (b) begin
      nx = t & 16'hFFFE;
      m_valid = 1'b0; m_instr = 16'h0000; m_pcn = 16'h0000;
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (t[0]) m_mis = 1'b1;
    end else if (s) begin
      nx = m_pc;
    end else begin
      nx = m_pc + 16'd2;
      m_valid = 1'b1; m_instr = mem[m_pc[8:1]]; m_pcn = m_pc + 16'd2;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
    e = '{pc: m_pc, new_pc: nx, valid: m_valid, instr: m_instr, pcn: m_pcn,
          fc: m_fc, sc: m_sc, mis: m_mis};
    #1;
    q.push_back(e);
    pushed++;
    m_pc = nx;
  endtask

  // asynchronous pulse well away from clock edges; outputs must clear at once
  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", {15'b0, if_id_valid}, 16'h0000);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc_next", if_id_pc_next, 16'h0000);
    chk("rst_misalign", {15'b0, misalign}, 16'h0000);
    chk("rst_fetch_count", fetch_count, 16'h0000);
    chk("rst_squash_count", squash_count, 16'h0000);
    chk("rst_new_pc", new_pc, pc);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // monitor: combinational outputs before the edge, registered ones after
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q[0];
        chk("new_pc", new_pc, e.new_pc);
        chk("imem_addr", imem_addr, e.pc);
        @(posedge clk);
        #1;
        e = q.pop_front();
        popped++;
        chk("if_id_valid", {15'b0, if_id_valid}, {15'b0, e.valid});
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc_next", if_id_pc_next, e.pcn);
        chk("fetch_count", fetch_count, e.fc);
        chk("squash_count", squash_count, e.sc);
        chk("misalign", {15'b0, misalign}, {15'b0, e.mis});
      end
    end
  end

  initial begin : stim
    logic [15:0] r;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    model_reset();
    m_pc = 16'h0000;

    // boot then two sequential fetches
    pulse_reset();
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // three-cycle stall at 0x0010 then release
    m_pc = 16'h0010;
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // redirect wins over stall
    step(1, 1, 16'h0040);
    step(0, 0, 16'h0000);

    // odd target aligns down and sets the sticky flag
    step(0, 1, 16'h0041);
    step(0, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // PC wrap
    m_pc = 16'hFFFE;
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // reset in the middle of HOLD, then boot again
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    pulse_reset();
    step(1, 1, 16'h0033);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // randomized traffic with occasional PC jumps and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        r = 16'($urandom);
        m_pc = {r[15:1], 1'b0};
      end
      if ($urandom_range(0, 49) == 0) m_pc = 16'hFFFE;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (popped != pushed) begin
      fails++;
      $display("FAIL drain: checked %0d expected %0d", popped, pushed);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
